decode_sched: RTL and testbench
===============================

// Module: decode_sched
// PURPOSE
//   Instruction issue scheduler between the fetch unit and decode stage 1.
//   Buffers fetched {PC, instruction} pairs in a small FIFO.
//   Presents the oldest pair to decode_1 and sequences it through run, stall and flush.
//   Decouples fetch from back-pressure: decode_1 captures every cycle and has no ready of its own.
// PARAMETERS
//   DEPTH   4   FIFO entries; power of two, >=2
//   PTR_W   $clog2(DEPTH)   localparam, pointer width; count is PTR_W+1 bits
// PORTS
//   CLK          in   1      clock; all state updates on posedge
//   RST          in   1      reset, asynchronous, active-low
//   FETCH_VALID  in   1      fetch offers a pair this cycle
//   FETCH_PC     in   32     PC of offered instruction
//   FETCH_DATA   in   32     offered instruction word
//   FETCH_READY  out  1      scheduler accepts the pair this cycle
//   STALL        in   1      downstream hazard; hold current issue
//   FLUSH        in   1      branch/trap redirect; discard all buffered pairs
//   INST_VALID   out  1      pair presented to decode_1
//   INST_PC      out  32     PC of presented pair
//   INST_DATA    out  32     instruction of presented pair
//   LEVEL        out  PTR_W+1  current FIFO occupancy
// BEHAVIOUR
//   Reset (RST=0, async): count=0, pointers=0, state=EMPTY.
//   Reset values: INST_VALID=0, INST_PC=0, INST_DATA=0, LEVEL=0, FETCH_READY=0.
//   FETCH_READY rises in the first cycle after RST deasserts.
//   Push = FETCH_VALID & FETCH_READY. Pop (issue) = INST_VALID & !STALL.
//   FETCH_READY = (count<DEPTH) & (state!=FLUSH).
//   Full + pop in the same cycle does NOT raise FETCH_READY: no pass-through when full.
//   INST_* = FIFO head entry; INST_VALID = (count!=0) & (state!=FLUSH).
//   Latency: a pair pushed at edge N is presented from cycle N+1.
//   While STALL=1, INST_* are held bit-stable; pushes continue until full.
//   Pointers wrap modulo DEPTH. Push+pop in the same cycle: count unchanged.
//   States:
//     EMPTY: count==0.
//       -> RUN on push.
//     RUN: count>0, STALL=0.
//       -> STALL when STALL=1.
//       -> EMPTY on pop of last entry with no push.
//     STALL: count>0, STALL=1.
//       -> RUN when STALL=0.
//     FLUSH: single cycle; INST_VALID=0, FETCH_READY=0.
//       -> EMPTY unconditionally.
//   FLUSH=1 in any state: next edge clears count/pointers and enters FLUSH.
//   A same-cycle push is dropped; FLUSH has priority over STALL, push and pop.
//   FLUSH held high for several cycles: stays in FLUSH, FETCH_READY remains 0.
//   Reset mid-operation: all entries lost, no partial issue.
// CONFIGURATION
//   DECODE_SCHED_BYPASS_EN defined:
//     When count==0, state!=FLUSH and FETCH_VALID=1, the block drives INST_VALID=1
//     and INST_PC/INST_DATA = FETCH_PC/FETCH_DATA combinationally: zero latency.
//     If STALL=0 as well, the pair issues without being written into the FIFO.
//     If STALL=1, the pair is written and held as the head.
//   DECODE_SCHED_BYPASS_EN undefined:
//     Latency is always 1 cycle as above; no combinational fetch->decode path.
// STRUCTURE
//   Shared package/header: state encoding SCHED_EMPTY/RUN/STALL/FLUSH (2 bits),
//   XLEN=32, and the NOP value 32'h0000_0013 for benches.
//   One sub-module: sched_fifo (storage, pointers, count).
//   The FSM and handshake logic stay in decode_sched.
// TESTING
//   T1 reset: RST=0 with FETCH_VALID=1 -> INST_VALID=0, LEVEL=0, FETCH_READY=0;
//      release -> FETCH_READY=1 next cycle.
//   T2 stream: push PC 0x0,0x4,0x8 on consecutive cycles with STALL=0 ->
//      INST_PC 0x0,0x4,0x8 one cycle later each; LEVEL never exceeds 1.
//   T3 stall/full: STALL=1 and push 5 pairs (DEPTH=4) -> FETCH_READY=0 after 4 pushes;
//      INST_PC stays 0x0 and LEVEL=4. Drop STALL -> in-order issue 0x0..0xC, then the 5th.
//   T4 flush: LEVEL=3 with FLUSH=1 and FETCH_VALID=1 in the same cycle ->
//      next cycle INST_VALID=0 and LEVEL=0; the pushed pair never issues.
//   T5 wrap: 10 push/pop cycles with DEPTH=4 -> order preserved across pointer wrap.
//   T6 bypass (macro defined): count=0, FETCH_VALID=1, FETCH_PC=0x100, STALL=0 ->
//      INST_VALID=1, INST_PC=0x100 in the same cycle; LEVEL stays 0.

Source files
------------

// File: rtl/decode_sched_pkg.sv
// rtl/decode_sched_pkg.sv - shared types and constants for the decode issue scheduler
package decode_sched_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      SCHED_EMPTY = 2'd0,
      SCHED_RUN   = 2'd1,
      SCHED_STALL = 2'd2,
      SCHED_FLUSH = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } inst_pair_t;

endpackage

// File: rtl/decode_sched_fifo.sv
// rtl/decode_sched_fifo.sv - {PC, instruction} storage FIFO with wrap-around pointers and occupancy count
module decode_sched_fifo
   import decode_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  inst_pair_t       wr_pair,
   output inst_pair_t       head,
   output logic [PTR_W:0]   count
);

   inst_pair_t       mem_q [DEPTH];
   inst_pair_t       mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   // Clear wins over any same-cycle push or pop; pointers wrap naturally at DEPTH.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wr_pair;
            wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/decode_sched.sv
// rtl/decode_sched.sv - fetch-to-decode_1 issue scheduler with run/stall/flush sequencing
// Optional zero-latency fetch bypass when DECODE_SCHED_BYPASS_EN is defined.
module decode_sched
   import decode_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FETCH_VALID,
   input  logic [XLEN-1:0]   FETCH_PC,
   input  logic [XLEN-1:0]   FETCH_DATA,
   output logic              FETCH_READY,
   input  logic              STALL,
   input  logic              FLUSH,
   output logic              INST_VALID,
   output logic [XLEN-1:0]   INST_PC,
   output logic [XLEN-1:0]   INST_DATA,
   output logic [PTR_W:0]    LEVEL
);

   localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

   sched_state_e   state_q, state_d;
   logic           init_q, init_d;
   logic           fetch_ready;
   logic           fifo_valid;
   logic           push;
   logic           fifo_push;
   logic           fifo_pop;
   logic           inst_valid;
   logic [PTR_W:0] count;
   logic [PTR_W:0] level_next;
   inst_pair_t     head;
   inst_pair_t     fetch_pair;
   inst_pair_t     pres;

   assign fetch_pair = '{pc: FETCH_PC, data: FETCH_DATA};

   decode_sched_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RST),
      .clear   (FLUSH),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_pair (fetch_pair),
      .head    (head),
      .count   (count)
   );

   // Full never accepts, even when the head issues this cycle: no pass-through.
   always_comb begin
      fetch_ready = init_q && (count != FULL_LVL) && (state_q != SCHED_FLUSH);
      fifo_valid  = (count != '0) && (state_q != SCHED_FLUSH);
      push        = FETCH_VALID && fetch_ready;
      inst_valid  = fifo_valid;
      pres        = head;
      fifo_push   = push;
      fifo_pop    = fifo_valid && !STALL;
`ifdef DECODE_SCHED_BYPASS_EN
      if (push && (count == '0)) begin
         inst_valid = 1'b1;
         pres       = fetch_pair;
         fifo_push  = STALL;
      end
`endif
      level_next = count + {{PTR_W{1'b0}}, fifo_push} - {{PTR_W{1'b0}}, fifo_pop};
   end

   always_comb begin
      state_d = state_q;
      init_d  = 1'b1;
      if (FLUSH) begin
         state_d = SCHED_FLUSH;
      end else begin
         case (state_q)
            SCHED_EMPTY: if (fifo_push) state_d = SCHED_RUN;
            SCHED_RUN: begin
               if (level_next == '0) state_d = SCHED_EMPTY;
               else if (STALL)       state_d = SCHED_STALL;
            end
            SCHED_STALL: begin
               if (!STALL) state_d = (level_next == '0) ? SCHED_EMPTY : SCHED_RUN;
            end
            SCHED_FLUSH: state_d = SCHED_EMPTY;
            default:     state_d = SCHED_EMPTY;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= SCHED_EMPTY;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= init_d;
      end
   end

   assign FETCH_READY = fetch_ready;
   assign INST_VALID  = inst_valid;
   assign INST_PC     = inst_valid ? pres.pc   : '0;
   assign INST_DATA   = inst_valid ? pres.data : '0;
   assign LEVEL       = count;

endmodule

// File: tb/tb_decode_sched.sv
// tb/tb_decode_sched.sv - self-checking bench: directed vector table, corner sequences, random vs queue model
module tb_decode_sched;
   import decode_sched_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [31:0] DKEY = 32'hA5A5_0000;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        FETCH_VALID = 1'b0;
   logic [31:0] FETCH_PC = '0;
   logic [31:0] FETCH_DATA = '0;
   logic        FETCH_READY;
   logic        STALL = 1'b0;
   logic        FLUSH = 1'b0;
   logic        INST_VALID;
   logic [31:0] INST_PC;
   logic [31:0] INST_DATA;
   logic [2:0]  LEVEL;

   int errors = 0;
   int checks = 0;

   decode_sched #(.DEPTH(DEPTH)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .FETCH_VALID (FETCH_VALID),
      .FETCH_PC    (FETCH_PC),
      .FETCH_DATA  (FETCH_DATA),
      .FETCH_READY (FETCH_READY),
      .STALL       (STALL),
      .FLUSH       (FLUSH),
      .INST_VALID  (INST_VALID),
      .INST_PC     (INST_PC),
      .INST_DATA   (INST_DATA),
      .LEVEL       (LEVEL)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        fv;
      logic [31:0] pc;
      logic        stall;
      logic        flush;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_ready;
      logic [2:0]  exp_level;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic fv, input logic [31:0] pc, input logic stall, input logic flush,
                      input logic ev, input logic [31:0] epc, input logic er, input logic [2:0] el);
      vec_t v;
      v.fv = fv; v.pc = pc; v.stall = stall; v.flush = flush;
      v.exp_valid = ev; v.exp_pc = epc; v.exp_ready = er; v.exp_level = el;
      tbl.push_back(v);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } pair_t;

   pair_t q[$];
   bit    m_init = 0;
   bit    m_flush_st = 0;

   task automatic model_cycle(input logic fv, input logic [31:0] pc, input logic [31:0] data,
                              input logic stall, input logic flush);
      bit    m_ready, m_push, m_valid;
      pair_t hd;
      FETCH_VALID = fv; FETCH_PC = pc; FETCH_DATA = data; STALL = stall; FLUSH = flush;
      #1;
      m_ready = m_init && !m_flush_st && (q.size() < DEPTH);
      m_push  = fv && m_ready;
      m_valid = !m_flush_st && (q.size() != 0);
      hd      = (q.size() != 0) ? q[0] : pair_t'({pc, data});
`ifdef DECODE_SCHED_BYPASS_EN
      if (m_push && q.size() == 0) m_valid = 1;
`endif
      chk("rnd_ready", {31'd0, FETCH_READY}, {31'd0, m_ready});
      chk("rnd_valid", {31'd0, INST_VALID}, {31'd0, m_valid});
      chk("rnd_level", {29'd0, LEVEL}, q.size());
      if (m_valid) begin
         chk("rnd_pc", INST_PC, hd.pc);
         chk("rnd_data", INST_DATA, hd.data);
      end
      @(posedge CLK);
      if (flush) begin
         q.delete();
         m_flush_st = 1;
      end else begin
         m_flush_st = 0;
         if (m_push) q.push_back(pair_t'({pc, data}));
         if (m_valid && !stall) void'(q.pop_front());
      end
      m_init = 1;
      @(negedge CLK);
   endtask

   initial begin
      logic [31:0] pc_seq;

      // T1: reset holds everything idle even with fetch offering
      RST = 0; FETCH_VALID = 1; FETCH_PC = 32'h55; FETCH_DATA = NOP;
      repeat (3) @(posedge CLK);
      @(negedge CLK); #1;
      chk("rst_valid", {31'd0, INST_VALID}, 32'd0);
      chk("rst_level", {29'd0, LEVEL}, 32'd0);
      chk("rst_ready", {31'd0, FETCH_READY}, 32'd0);
      chk("rst_pc", INST_PC, 32'd0);
      chk("rst_data", INST_DATA, 32'd0);
      @(negedge CLK);
      FETCH_VALID = 0; RST = 1;
      @(posedge CLK); @(negedge CLK); #1;
      chk("rel_ready", {31'd0, FETCH_READY}, 32'd1);
      chk("rel_level", {29'd0, LEVEL}, 32'd0);
      @(negedge CLK);

`ifndef DECODE_SCHED_BYPASS_EN
      // T2 stream
      add(1, 32'h0, 0, 0, 0, 32'h0, 1, 0);
      add(1, 32'h4, 0, 0, 1, 32'h0, 1, 1);
      add(1, 32'h8, 0, 0, 1, 32'h4, 1, 1);
      add(0, 32'h0, 0, 0, 1, 32'h8, 1, 1);
      add(0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
      // T3 stall until full, then drain in order
      add(1, 32'h0,  1, 0, 0, 32'h0,  1, 0);
      add(1, 32'h4,  1, 0, 1, 32'h0,  1, 1);
      add(1, 32'h8,  1, 0, 1, 32'h0,  1, 2);
      add(1, 32'hC,  1, 0, 1, 32'h0,  1, 3);
      add(1, 32'h10, 1, 0, 1, 32'h0,  0, 4);
      add(1, 32'h10, 1, 0, 1, 32'h0,  0, 4);
      add(1, 32'h10, 0, 0, 1, 32'h0,  0, 4);
      add(1, 32'h10, 0, 0, 1, 32'h4,  1, 3);
      add(0, 32'h0,  0, 0, 1, 32'h8,  1, 3);
      add(0, 32'h0,  0, 0, 1, 32'hC,  1, 2);
      add(0, 32'h0,  0, 0, 1, 32'h10, 1, 1);
      add(0, 32'h0,  0, 0, 0, 32'h0,  1, 0);
      // T4 flush at level 3 with a same-cycle push
      add(1, 32'h20, 1, 0, 0, 32'h0,  1, 0);
      add(1, 32'h24, 1, 0, 1, 32'h20, 1, 1);
      add(1, 32'h28, 1, 0, 1, 32'h20, 1, 2);
      add(1, 32'h2C, 1, 1, 1, 32'h20, 1, 3);
      add(1, 32'h30, 0, 0, 0, 32'h0,  0, 0);
      add(0, 32'h0,  0, 0, 0, 32'h0,  1, 0);
      // flush held for several cycles
      add(1, 32'h40, 0, 1, 0, 32'h0, 1, 0);
      add(1, 32'h44, 0, 1, 0, 32'h0, 0, 0);
      add(1, 32'h48, 0, 1, 0, 32'h0, 0, 0);
      add(0, 32'h0,  0, 0, 0, 32'h0, 0, 0);
      add(0, 32'h0,  0, 0, 0, 32'h0, 1, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         FETCH_VALID = tbl[i].fv; FETCH_PC = tbl[i].pc; FETCH_DATA = tbl[i].pc ^ DKEY;
         STALL = tbl[i].stall; FLUSH = tbl[i].flush;
         #1;
         chk($sformatf("vec%0d_valid", i), {31'd0, INST_VALID}, {31'd0, tbl[i].exp_valid});
         chk($sformatf("vec%0d_ready", i), {31'd0, FETCH_READY}, {31'd0, tbl[i].exp_ready});
         chk($sformatf("vec%0d_level", i), {29'd0, LEVEL}, {29'd0, tbl[i].exp_level});
         if (tbl[i].exp_valid) begin
            chk($sformatf("vec%0d_pc", i), INST_PC, tbl[i].exp_pc);
            chk($sformatf("vec%0d_data", i), INST_DATA, tbl[i].exp_pc ^ DKEY);
         end
         @(posedge CLK); @(negedge CLK);
      end
`else
      // T6 zero-latency bypass from empty
      FETCH_VALID = 1; FETCH_PC = 32'h100; FETCH_DATA = NOP; STALL = 0; FLUSH = 0;
      #1;
      chk("byp_valid", {31'd0, INST_VALID}, 32'd1);
      chk("byp_pc", INST_PC, 32'h100);
      chk("byp_data", INST_DATA, NOP);
      chk("byp_level", {29'd0, LEVEL}, 32'd0);
      @(posedge CLK); @(negedge CLK);
      FETCH_VALID = 0; #1;
      chk("byp_level_after", {29'd0, LEVEL}, 32'd0);
      chk("byp_valid_after", {31'd0, INST_VALID}, 32'd0);
      @(negedge CLK);
`endif

      // model takes over from an idle, empty, ready scheduler
      FETCH_VALID = 0; STALL = 0; FLUSH = 0;
      q.delete(); m_init = 1; m_flush_st = 0;

      // T5 pointer wrap: prefill two, then stream ten with continuous issue
      pc_seq = 32'h1000;
      for (int i = 0; i < 2; i++) begin
         model_cycle(1, pc_seq, pc_seq ^ DKEY, 1, 0);
         pc_seq += 4;
      end
      for (int i = 0; i < 10; i++) begin
         model_cycle(1, pc_seq, pc_seq ^ DKEY, 0, 0);
         pc_seq += 4;
      end
      for (int i = 0; i < 4; i++) model_cycle(0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic fv, st, fl;
         fv = ($urandom_range(0, 99) < 70);
         st = ($urandom_range(0, 99) < 35);
         fl = ($urandom_range(0, 99) < 4);
         model_cycle(fv, pc_seq, $urandom, st, fl);
         pc_seq += 4;
      end

      // reset in the middle of operation loses all entries
      for (int i = 0; i < 3; i++) begin
         model_cycle(1, pc_seq, pc_seq ^ DKEY, 1, 0);
         pc_seq += 4;
      end
      #2; RST = 0; #1;
      chk("midrst_level", {29'd0, LEVEL}, 32'd0);
      chk("midrst_valid", {31'd0, INST_VALID}, 32'd0);
      chk("midrst_ready", {31'd0, FETCH_READY}, 32'd0);
      @(negedge CLK);
      FETCH_VALID = 0; STALL = 0; RST = 1;
      @(posedge CLK); @(negedge CLK);
      q.delete(); m_init = 1; m_flush_st = 0;
      for (int i = 0; i < 60; i++) begin
         model_cycle($urandom_range(0, 1), pc_seq, $urandom, ($urandom_range(0, 3) == 0), 0);
         pc_seq += 4;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
